// File: rtl/tcdm_pkg.sv
// Shared TCDM types and the round-robin pick helper used by the bank arbiters.
package tcdm_pkg;

  localparam int unsigned TcdmAddrWidth = 12;
  localparam int unsigned TcdmDataWidth = 32;
  localparam int unsigned TcdmBeWidth   = TcdmDataWidth / 8;
  localparam int unsigned MaxReq        = 64;

  typedef struct packed {
    logic                     wen;
    logic [TcdmBeWidth-1:0]   be;
    logic [TcdmAddrWidth-1:0] add;
    logic [TcdmDataWidth-1:0] wdata;
  } tcdm_req_t;

  // First set bit of req scanning upward from ptr, wrapping at n; returns ptr if none.
  function automatic int unsigned rr_pick(input logic [MaxReq-1:0] req,
                                          input int unsigned       ptr,
                                          input int unsigned       n);
    int unsigned idx;
    bit          found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[$clog2(MaxReq)-1:0]]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/tcdm_resp_pipe.sv
// Fixed-latency {valid, idx} response tracker with one-hot response decode.
// TCDM_ARB_RESP_REG_EN adds a registered output stage for rvld_o/rdata_o.
module tcdm_resp_pipe #(
  parameter int unsigned Depth     = 1,
  parameter int unsigned IdxW      = 1,
  parameter int unsigned NumReq    = 2,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 vld_i,
  input  logic [IdxW-1:0]      idx_i,
  input  logic [DataWidth-1:0] rdata_i,
  output logic [NumReq-1:0]    rvld_o,
  output logic [DataWidth-1:0] rdata_o
);

  logic [Depth-1:0]           vld_q;
  logic [Depth-1:0][IdxW-1:0] idx_q;
  logic [NumReq-1:0]          rvld_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      idx_q[0] <= idx_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  always_comb begin
    rvld_d = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      rvld_d[i] = vld_q[Depth-1] && (idx_q[Depth-1] == IdxW'(i));
    end
  end

`ifdef TCDM_ARB_RESP_REG_EN
  logic [NumReq-1:0]    rvld_q;
  logic [DataWidth-1:0] rdata_q;

  // rdata is only captured with a live response so it holds between responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvld_q  <= '0;
      rdata_q <= '0;
    end else begin
      rvld_q <= rvld_d;
      if (vld_q[Depth-1]) rdata_q <= rdata_i;
    end
  end

  assign rvld_o  = rvld_q;
  assign rdata_o = rdata_q;
`else
  assign rvld_o  = rvld_d;
  assign rdata_o = rdata_i;
`endif

endmodule

// File: rtl/tcdm_bank_arb.sv
// Single-bank TCDM round-robin arbiter with fixed-latency response routing.
// Optional TCDM_ARB_RESP_REG_EN registers the response outputs (one extra cycle).
module tcdm_bank_arb
  import tcdm_pkg::*;
#(
  parameter int unsigned NumReq       = 8,
  parameter int unsigned AddrMemWidth = 12,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned MemLatency   = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumReq-1:0]                     req_i,
  input  logic [NumReq-1:0][AddrMemWidth-1:0]   add_i,
  input  logic [NumReq-1:0]                     wen_i,
  input  logic [NumReq-1:0][DataWidth-1:0]      wdata_i,
  input  logic [NumReq-1:0][BeWidth-1:0]        be_i,
  output logic [NumReq-1:0]                     gnt_o,
  output logic [NumReq-1:0]                     rvld_o,
  output logic [DataWidth-1:0]                  rdata_o,
  output logic                                  cs_o,
  output logic [AddrMemWidth-1:0]               add_o,
  output logic                                  wen_o,
  output logic [DataWidth-1:0]                  wdata_o,
  output logic [BeWidth-1:0]                    be_o,
  input  logic [DataWidth-1:0]                  rdata_i
);

  localparam int unsigned IdxW     = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PipeDepth = (MemLatency > 0) ? MemLatency : 1;

  if (MemLatency == 0) begin : g_lat_chk
    $fatal(1, "tcdm_bank_arb: MemLatency must be at least 1");
  end
  if (NumReq > MaxReq) begin : g_req_chk
    $fatal(1, "tcdm_bank_arb: NumReq exceeds tcdm_pkg::MaxReq");
  end

  // Same layout as tcdm_pkg::tcdm_req_t, sized by this instance's parameters.
  typedef struct packed {
    logic                    wen;
    logic [BeWidth-1:0]      be;
    logic [AddrMemWidth-1:0] add;
    logic [DataWidth-1:0]    wdata;
  } bank_req_t;

  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   winner;
  logic [IdxW-1:0]   ptr_nxt;
  logic [MaxReq-1:0] req_ext;
  bank_req_t         sel_req;

  always_comb begin
    req_ext              = '0;
    req_ext[NumReq-1:0]  = req_i;
  end

  assign cs_o    = |req_i;
  assign winner  = IdxW'(rr_pick(req_ext, 32'(ptr_q), NumReq));
  assign ptr_nxt = (32'(winner) == NumReq - 1) ? '0 : winner + 1'b1;

  always_comb begin
    gnt_o = '0;
    if (cs_o) gnt_o[winner] = 1'b1;
  end

  // With no request the mux index is the held pointer, so the bank fields stay stable.
  always_comb begin
    sel_req.wen   = wen_i[winner];
    sel_req.be    = be_i[winner];
    sel_req.add   = add_i[winner];
    sel_req.wdata = wdata_i[winner];
  end

  assign add_o   = sel_req.add;
  assign wen_o   = sel_req.wen;
  assign wdata_o = sel_req.wdata;
  assign be_o    = sel_req.be;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (cs_o) begin
      ptr_q <= ptr_nxt;
    end
  end

  tcdm_resp_pipe #(
    .Depth     (PipeDepth),
    .IdxW      (IdxW),
    .NumReq    (NumReq),
    .DataWidth (DataWidth)
  ) i_resp_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .vld_i   (cs_o),
    .idx_i   (winner),
    .rdata_i (rdata_i),
    .rvld_o  (rvld_o),
    .rdata_o (rdata_o)
  );

endmodule

// File: tb/tb_tcdm_bank_arb.sv
// Scoreboard bench for tcdm_bank_arb (NumReq=8, MemLatency=3); honours TCDM_ARB_RESP_REG_EN.
module tb_tcdm_bank_arb;

  localparam int unsigned NR = 8;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned ML = 3;
`ifdef TCDM_ARB_RESP_REG_EN
  localparam int unsigned LAT = ML + 1;
`else
  localparam int unsigned LAT = ML;
`endif

  logic                       clk;
  logic                       rst_ni;
  logic [NR-1:0]              req_i;
  logic [NR-1:0][AW-1:0]      add_i;
  logic [NR-1:0]              wen_i;
  logic [NR-1:0][DW-1:0]      wdata_i;
  logic [NR-1:0][BW-1:0]      be_i;
  logic [NR-1:0]              gnt_o;
  logic [NR-1:0]              rvld_o;
  logic [DW-1:0]              rdata_o;
  logic                       cs_o;
  logic [AW-1:0]              add_o;
  logic                       wen_o;
  logic [DW-1:0]              wdata_o;
  logic [BW-1:0]              be_o;
  logic [DW-1:0]              rdata_i;

  tcdm_bank_arb #(
    .NumReq       (NR),
    .AddrMemWidth (AW),
    .DataWidth    (DW),
    .BeWidth      (BW),
    .MemLatency   (ML)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .add_i   (add_i),
    .wen_i   (wen_i),
    .wdata_i (wdata_i),
    .be_i    (be_i),
    .gnt_o   (gnt_o),
    .rvld_o  (rvld_o),
    .rdata_o (rdata_o),
    .cs_o    (cs_o),
    .add_o   (add_o),
    .wen_o   (wen_o),
    .wdata_o (wdata_o),
    .be_o    (be_o),
    .rdata_i (rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    int unsigned idx;
  } resp_t;

  resp_t         sbq[$];
  int            n_tests;
  int            n_fail;
  int unsigned   cyc;
  int unsigned   ptr_m;
  logic [DW-1:0] hist[0:1023];
  logic [DW-1:0] last_rdata;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic check_resp();
    logic [NR-1:0] exp_v;
    logic [DW-1:0] exp_d;
    exp_v = '0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      exp_v[sbq[0].idx] = 1'b1;
`ifdef TCDM_ARB_RESP_REG_EN
      exp_d = hist[cyc-1];
`else
      exp_d = hist[cyc];
`endif
      last_rdata = exp_d;
      void'(sbq.pop_front());
      chk("rvld", 64'(rvld_o), 64'(exp_v));
      chk("rdata", 64'(rdata_o), 64'(exp_d));
    end else begin
      chk("rvld_idle", 64'(rvld_o), 64'(exp_v));
`ifdef TCDM_ARB_RESP_REG_EN
      chk("rdata_hold", 64'(rdata_o), 64'(last_rdata));
`else
      chk("rdata_wire", 64'(rdata_o), 64'(hist[cyc]));
`endif
    end
  endtask

  // One bus cycle: drive, optionally pulse reset, then check grant and response.
  task automatic step(input logic [NR-1:0] req, input bit rnd, input bit rst_pulse);
    int            win;
    int unsigned   idx;
    logic [NR-1:0] exp_g;
    @(posedge clk);
    #1;
    cyc++;
    req_i = req;
    if (rnd) begin
      for (int i = 0; i < NR; i++) begin
        add_i[i]   = AW'($urandom);
        wen_i[i]   = 1'($urandom);
        wdata_i[i] = $urandom;
        be_i[i]    = BW'($urandom);
      end
    end
    rdata_i   = $urandom;
    hist[cyc] = rdata_i;
    if (rst_pulse) begin
      rst_ni = 1'b0;
      #1;
      rst_ni = 1'b1;
      sbq.delete();
      ptr_m      = 0;
      last_rdata = '0;
    end
    #2;
    check_resp();
    win = -1;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = (ptr_m + k) % NR;
      if (win < 0 && req[idx]) win = int'(idx);
    end
    exp_g = '0;
    if (win >= 0) exp_g[win] = 1'b1;
    chk("gnt", 64'(gnt_o), 64'(exp_g));
    chk("cs", 64'(cs_o), 64'(|req));
    if (win >= 0) begin
      chk("add", 64'(add_o), 64'(add_i[win]));
      chk("wen", 64'(wen_o), 64'(wen_i[win]));
      chk("wdata", 64'(wdata_o), 64'(wdata_i[win]));
      chk("be", 64'(be_o), 64'(be_i[win]));
      ptr_m = (int'(win) + 1) % NR;
      sbq.push_back('{cyc + LAT, int'(win)});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [NR-1:0] r;
    n_tests    = 0;
    n_fail     = 0;
    cyc        = 0;
    ptr_m      = 0;
    last_rdata = '0;
    rst_ni     = 1'b0;
    req_i      = '0;
    add_i      = '0;
    wen_i      = '0;
    wdata_i    = '0;
    be_i       = '0;
    rdata_i    = '0;
    hist[0]    = '0;

    #12;
    chk("rst_rvld", 64'(rvld_o), 64'(0));
    chk("rst_cs", 64'(cs_o), 64'(0));
`ifdef TCDM_ARB_RESP_REG_EN
    chk("rst_rdata", 64'(rdata_o), 64'(0));
`endif
    req_i = 8'h04;
    #1;
    chk("rst_gnt_follow", 64'(gnt_o), 64'(8'h04));
    chk("rst_cs_follow", 64'(cs_o), 64'(1));
    req_i = '0;
    #4;
    rst_ni = 1'b1;

    // single requester load at 0x123
    add_i[0] = 12'h123;
    wen_i[0] = 1'b1;
    step(8'h01, 1'b0, 1'b0);
    chk("single_add", 64'(add_o), 64'(12'h123));
    idle(LAT + 1);

    // fairness from reset: 0x05 -> 01,04,01,04
    step('0, 1'b1, 1'b1);
    repeat (4) step(8'h05, 1'b1, 1'b0);
    idle(LAT + 1);

    // wrap-around through port 7
    step(8'h80, 1'b1, 1'b0);
    step(8'h81, 1'b1, 1'b0);
    step(8'h81, 1'b1, 1'b0);
    idle(LAT + 1);

    // pipelined back-to-back grants to 2, 5, 6
    step(8'h04, 1'b1, 1'b0);
    step(8'h20, 1'b1, 1'b0);
    step(8'h40, 1'b1, 1'b0);
    idle(LAT + 2);

    // reset while a response is in flight
    step(8'h08, 1'b1, 1'b0);
    step('0, 1'b1, 1'b1);
    idle(LAT + 2);
    step(8'hFF, 1'b1, 1'b0);
    idle(LAT + 1);

    // random traffic with idle gaps
    repeat (200) begin
      r = NR'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      step(r, 1'b1, 1'b0);
    end
    idle(LAT + 2);
    chk("sb_drained", 64'(sbq.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
